rand_pool: RTL and testbench
============================

# rand_pool

Randomness buffer between the SHAKE256 DRBG and the masked Gaussian sampler. It autonomously requests 32-bit words from the DRBG, stores them in a small first-word-fall-through FIFO, and serves them to the sampler over a valid/ready handshake. It also enforces a reseed interval: after a fixed number of words it stops requesting output and raises a reseed request to the seeder.

## Interface
- WORD_WIDTH, 32: DRBG word and pool entry width.
- DEPTH, 8: FIFO entries; power of two, at least 2.
- RESEED_INTERVAL, 1024: words accepted from the DRBG between reseeds; at least 1.
- TIMEOUT, 255: maximum cycles to wait for `drbg_valid` after a request.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- drbg_gen  out  1  one-cycle generate request to the DRBG.
- drbg_valid  in  1  DRBG word-valid pulse.
- drbg_data  in  WORD_WIDTH  DRBG word, sampled when `drbg_valid` is high.
- reseed_req  out  1  level; reseed interval reached.
- reseed_done  in  1  pulse from the seeder; DRBG has been reseeded.
- rd_valid  out  1  pool non-empty.
- rd_ready  in  1  consumer accepts the head word.
- rd_data  out  WORD_WIDTH  head word (FWFT).
- fill  out  $clog2(DEPTH)+1  current occupancy.
- timeout_err  out  1  sticky; a request timed out.
- health_fail  out  1  sticky; repetition test failed (see Configuration).

## Operation
- FSM states: IDLE, WAIT, RESEED.
- IDLE:
  - If `word_cnt == RESEED_INTERVAL`: assert `reseed_req` and go to RESEED.
  - Else if `fill < DEPTH`: register `drbg_gen=1` for one cycle, clear the timeout counter, and go to WAIT.
  - Else stay in IDLE.
- WAIT:
  - On `drbg_valid`: write `drbg_data` at the write pointer, increment `word_cnt`, and go to IDLE.
  - If the timeout counter reaches TIMEOUT: set `timeout_err` and go to IDLE; no write occurs.
- RESEED:
  - `reseed_req` is held high.
  - On `reseed_done`: clear `word_cnt`, deassert `reseed_req`, and go to IDLE.
  - No `drbg_gen` is issued while in RESEED, so the DRBG is guaranteed idle while it is reseeded.
- At most one request is outstanding at a time. A write therefore always has space and overflow is impossible.
- `drbg_valid` outside WAIT is ignored: no write, no count.
- `reseed_done` outside RESEED is ignored.
- Read: a transfer occurs when `rd_valid && rd_ready`. The read pointer advances and `fill` decrements.
- `rd_ready` while empty has no effect; there is no underflow.
- Simultaneous write and read: `fill` is unchanged and both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally. `fill` ranges from 0 to DEPTH.
- `word_cnt` is $clog2(RESEED_INTERVAL+1) bits and saturates at RESEED_INTERVAL.
- Stored words continue to be served during RESEED.

## Timing
- Reset values:
  - `drbg_gen=0`, `reseed_req=0`, `rd_valid=0`, `rd_data=0`.
  - `fill=0`, `timeout_err=0`, `health_fail=0`.
  - Storage is zeroed, FSM is in IDLE, `word_cnt=0`.
- The first `drbg_gen` pulse occurs in the first cycle after reset release.
- `drbg_gen` is a registered single-cycle pulse. It is never high on two consecutive cycles.
- A DRBG word arriving in cycle N appears as `rd_data` with `rd_valid=1` from cycle N+1.
- The next `drbg_gen` is issued no earlier than cycle N+1.
- `rd_data` always reflects the current head. After a read in cycle N, the next word is presented in cycle N+1.
- `reseed_req` rises one cycle after the accepted word that makes `word_cnt == RESEED_INTERVAL`.
- `reseed_req` falls one cycle after `reseed_done`.
- Asserting `rst` mid-WAIT or mid-RESEED discards all contents and counters immediately.
- A late `drbg_valid` that arrives after reset is ignored because the FSM is in IDLE.

## Configuration
- Macro: `RAND_POOL_HEALTH_EN`.
- Defined:
  - Each accepted DRBG word is compared with the previously accepted word. The comparison register resets to 0.
  - On equality: the word is discarded (no write, no `word_cnt` increment), `health_fail` is set sticky, and the FSM returns to IDLE.
  - While `health_fail=1`, no further `drbg_gen` is issued. Stored words remain readable.
- Undefined: no comparison logic is built, every word is written, and `health_fail` is tied to 0.

## Test plan
- Fill: DRBG model returns 0x11111111, 0x22222222, ... with 30-cycle latency, `rd_ready=0`. Required: `fill` reaches 8 and `drbg_gen` stops; `rd_data=0x11111111`.
- Drain with simultaneous write: full pool, `rd_ready=1` continuously. Required: words appear in order; `fill` stays constant on cycles with both a write and a read; no word is lost or duplicated.
- Reseed: RESEED_INTERVAL=4, `rd_ready=1`. Required:
  - exactly 4 `drbg_gen` pulses, then `reseed_req=1` with no further `drbg_gen`;
  - `reseed_done` pulse: `reseed_req=0` next cycle, then `drbg_gen` resumes.
- Timeout: DRBG model never answers, TIMEOUT=255. Required: `timeout_err=1` after 255 cycles in WAIT; a new `drbg_gen` is issued; the error stays set until `rst`.
- Stray and reset: a `drbg_valid` with 0xDEADBEEF in IDLE leaves `fill` unchanged; `rst` mid-WAIT gives `fill=0`, `rd_valid=0`, `rd_data=0`.
- Health (`RAND_POOL_HEALTH_EN` defined): DRBG returns 0xA5A5A5A5 twice. Required: `fill=1`, `health_fail=1`, no further `drbg_gen`. Without the macro: `fill=2`, `health_fail=0`.

Source files
------------

// File: rtl/rand_pool.sv
// Randomness pool: pulls DRBG words into a FWFT FIFO and enforces a reseed interval.
// Optional repetition health test is built when RAND_POOL_HEALTH_EN is defined.
module rand_pool #(
    parameter int WORD_WIDTH      = 32,
    parameter int DEPTH           = 8,
    parameter int RESEED_INTERVAL = 1024,
    parameter int TIMEOUT         = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     drbg_gen,
    input  logic                     drbg_valid,
    input  logic [WORD_WIDTH-1:0]    drbg_data,
    output logic                     reseed_req,
    input  logic                     reseed_done,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [WORD_WIDTH-1:0]    rd_data,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     timeout_err,
    output logic                     health_fail
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam int CW = $clog2(RESEED_INTERVAL + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESEED} state_t;

    state_t                state_q, state_d;
    logic                  gen_q, gen_d;
    logic                  rs_q, rs_d;
    logic                  to_err_q, to_err_d;
    logic [TW-1:0]         to_cnt_q, to_cnt_d;
    logic [CW-1:0]         wcnt_q, wcnt_d;
    logic [AW-1:0]         wptr_q, rptr_q;
    logic [FW-1:0]         fill_q;
    logic [WORD_WIDTH-1:0] mem_q [DEPTH];
    logic                  wr_en, rd_en;
    logic                  rep_hit;
    logic                  hf_q;

`ifdef RAND_POOL_HEALTH_EN
    logic [WORD_WIDTH-1:0] last_q;

    assign rep_hit = (drbg_data == last_q);

    // A repeated word is rejected in WAIT and latches the sticky failure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= '0;
            hf_q   <= 1'b0;
        end else begin
            if (wr_en)
                last_q <= drbg_data;
            if (state_q == WAIT && drbg_valid && rep_hit)
                hf_q <= 1'b1;
        end
    end
`else
    assign rep_hit = 1'b0;
    assign hf_q    = 1'b0;
`endif

    assign rd_en = rd_ready && (fill_q != '0);

    always_comb begin
        state_d  = state_q;
        gen_d    = 1'b0;
        rs_d     = rs_q;
        to_err_d = to_err_q;
        to_cnt_d = to_cnt_q;
        wcnt_d   = wcnt_q;
        wr_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (wcnt_q == CW'(RESEED_INTERVAL)) begin
                    rs_d    = 1'b1;
                    state_d = RESEED;
                end else if (fill_q < FW'(DEPTH) && !hf_q) begin
                    gen_d    = 1'b1;
                    to_cnt_d = '0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (drbg_valid) begin
                    state_d = IDLE;
                    if (!rep_hit) begin
                        wr_en = 1'b1;
                        if (wcnt_q != CW'(RESEED_INTERVAL))
                            wcnt_d = wcnt_q + 1'b1;
                        // Go straight to RESEED so reseed_req rises right after the last word.
                        if (wcnt_d == CW'(RESEED_INTERVAL)) begin
                            rs_d    = 1'b1;
                            state_d = RESEED;
                        end
                    end
                end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                    to_err_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            RESEED: begin
                if (reseed_done) begin
                    wcnt_d  = '0;
                    rs_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gen_q    <= 1'b0;
            rs_q     <= 1'b0;
            to_err_q <= 1'b0;
            to_cnt_q <= '0;
            wcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            gen_q    <= gen_d;
            rs_q     <= rs_d;
            to_err_q <= to_err_d;
            to_cnt_q <= to_cnt_d;
            wcnt_q   <= wcnt_d;
        end
    end

    // Only one request is ever outstanding, so a write always finds a free slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wptr_q] <= drbg_data;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (rd_en)
                rptr_q <= rptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
        end
    end

    assign drbg_gen    = gen_q;
    assign reseed_req  = rs_q;
    assign timeout_err = to_err_q;
    assign health_fail = hf_q;
    assign rd_valid    = (fill_q != '0);
    assign rd_data     = mem_q[rptr_q];
    assign fill        = fill_q;

endmodule

// File: tb/tb_rand_pool.sv
// Bench for rand_pool: queue-based pool model, DRBG/seeder responders, randomized traffic.
module tb_rand_pool;
    localparam int W     = 32;
    localparam int DEPTH = 8;
    localparam int RI    = 4;
    localparam int TO    = 255;
`ifdef RAND_POOL_HEALTH_EN
    localparam bit HEALTH = 1'b1;
`else
    localparam bit HEALTH = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   drbg_gen, drbg_valid, reseed_req, reseed_done;
    logic                   rd_valid, rd_ready, timeout_err, health_fail;
    logic [W-1:0]           drbg_data, rd_data;
    logic [$clog2(DEPTH):0] fill;

    always #5 clk = ~clk;

    rand_pool #(.WORD_WIDTH(W), .DEPTH(DEPTH), .RESEED_INTERVAL(RI), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .drbg_gen(drbg_gen), .drbg_valid(drbg_valid),
        .drbg_data(drbg_data), .reseed_req(reseed_req), .reseed_done(reseed_done),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .fill(fill),
        .timeout_err(timeout_err), .health_fail(health_fail)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference model of the pool
    logic [W-1:0] q[$];
    logic [W-1:0] src[$];
    logic [W-1:0] last;
    bit           pend, exp_rs, exp_to, exp_hf, gen_prev, resp_now;
    int           age, wcnt, k;
    // stimulus controls
    int           lat, lat_max, lat_cnt, resp_left, ready_mode, rs_delay, rs_cnt, gens, reads;
    bit           rnd_lat, auto_done, done_req, stray_req, sdone_req;

    task automatic cyc();
        if (rd_ready && q.size() > 0) begin
            chk("xfer_valid", 32'(rd_valid), 32'd1);
            chk("xfer_data", rd_data, q[0]);
            q.delete(0);
            reads++;
        end
        if (resp_now) begin
            if (HEALTH && drbg_data == last) begin
                exp_hf = 1'b1;
            end else begin
                q.push_back(drbg_data);
                last = drbg_data;
                wcnt++;
                if (wcnt == RI) exp_rs = 1'b1;
            end
        end
        if (reseed_done && exp_rs) begin
            exp_rs = 1'b0;
            wcnt   = 0;
        end
        @(posedge clk);
        #1;
        if (pend) begin
            age++;
            if (age == TO) begin
                pend   = 1'b0;
                exp_to = 1'b1;
            end
        end
        chk("fill", 32'(fill), 32'(q.size()));
        chk("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
        chk("reseed_req", 32'(reseed_req), 32'(exp_rs));
        chk("timeout_err", 32'(timeout_err), 32'(exp_to));
        chk("health_fail", 32'(health_fail), 32'(exp_hf));
        if (q.size() > 0) chk("head", rd_data, q[0]);
        if (drbg_gen) begin
            gens++;
            chk("gen_gap", 32'(gen_prev), 32'd0);
            chk("gen_outstanding", 32'(pend), 32'd0);
            chk("gen_in_reseed", 32'(exp_rs), 32'd0);
            chk("gen_after_hf", 32'(exp_hf), 32'd0);
            chk("gen_room", 32'(q.size() < DEPTH), 32'd1);
            pend    = 1'b1;
            age     = 0;
            lat_cnt = rnd_lat ? int'($urandom_range(lat_max, 0)) : lat;
        end
        gen_prev = drbg_gen;
        // drive inputs for the coming cycle
        drbg_valid = 1'b0;
        drbg_data  = $urandom;
        resp_now   = 1'b0;
        if (pend && resp_left != 0) begin
            if (lat_cnt == 0) begin
                drbg_valid = 1'b1;
                if (src.size() > 0) begin
                    drbg_data = src.pop_front();
                end else begin
                    drbg_data = 32'(32'h11111111 * k);
                    k++;
                end
                pend     = 1'b0;
                resp_now = 1'b1;
                if (resp_left > 0) resp_left--;
            end else begin
                lat_cnt--;
            end
        end else if (!pend && stray_req) begin
            drbg_valid = 1'b1;
            drbg_data  = 32'hDEADBEEF;
            stray_req  = 1'b0;
        end
        reseed_done = 1'b0;
        if (sdone_req && !reseed_req) begin
            reseed_done = 1'b1;
            sdone_req   = 1'b0;
        end else if (done_req) begin
            reseed_done = 1'b1;
            done_req    = 1'b0;
        end else if (auto_done && reseed_req) begin
            if (rs_cnt >= rs_delay) begin
                reseed_done = 1'b1;
                rs_cnt      = 0;
            end else begin
                rs_cnt++;
            end
        end
        case (ready_mode)
            0:       rd_ready = 1'b0;
            1:       rd_ready = 1'b1;
            default: rd_ready = 1'($urandom_range(1, 0));
        endcase
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without waiting for an edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_gen", 32'(drbg_gen), 32'd0);
        chk("rst_reseed_req", 32'(reseed_req), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        chk("rst_health", 32'(health_fail), 32'd0);
        q.delete();
        src.delete();
        pend = 0; age = 0; exp_rs = 0; exp_to = 0; exp_hf = 0; wcnt = 0; last = '0;
        gen_prev = 0; resp_now = 0; k = 1; rs_cnt = 0;
        done_req = 0; stray_req = 0; sdone_req = 0;
        drbg_valid = 1'b0; drbg_data = '0; reseed_done = 1'b0; rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int to_n;
        drbg_valid = 1'b0; drbg_data = '0; reseed_done = 1'b0; rd_ready = 1'b0;
        lat = 30; rnd_lat = 0; lat_max = 0; resp_left = -1; ready_mode = 0;
        auto_done = 1; rs_delay = 3; gens = 0; reads = 0;

        // fill with 30-cycle DRBG latency and no consumer
        do_reset();
        cyc();
        chk("first_gen", 32'(drbg_gen), 32'd1);
        for (int i = 0; i < 2000 && q.size() < DEPTH; i++) cyc();
        gens = 0;
        repeat (100) cyc();
        chk("fill_full", 32'(fill), 32'd8);
        chk("fill_gen_stops", 32'(gens), 32'd0);
        chk("fill_head", rd_data, 32'h11111111);

        // drain with concurrent writes
        ready_mode = 1; rnd_lat = 1; lat_max = 3; reads = 0;
        repeat (300) cyc();
        chk("drain_reads", 32'(reads >= 20), 32'd1);

        // randomized traffic with stray valids and stray reseed_done
        ready_mode = 2; lat_max = 40; reads = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(19, 0) == 0) stray_req = 1'b1;
            if ($urandom_range(29, 0) == 0) sdone_req = 1'b1;
            rs_delay = int'($urandom_range(6, 0));
            cyc();
        end
        chk("random_reads", 32'(reads > 0), 32'd1);

        // reseed interval
        auto_done = 0; ready_mode = 1; rnd_lat = 0; lat = 5;
        do_reset();
        gens = 0;
        for (int i = 0; i < 500 && !reseed_req; i++) cyc();
        chk("reseed_seen", 32'(reseed_req), 32'd1);
        chk("reseed_gens", 32'(gens), 32'd4);
        gens = 0;
        repeat (20) cyc();
        chk("reseed_hold", 32'(reseed_req), 32'd1);
        chk("reseed_nogen", 32'(gens), 32'd0);
        done_req = 1'b1;
        cyc();
        cyc();
        chk("reseed_fall", 32'(reseed_req), 32'd0);
        gens = 0;
        repeat (4) cyc();
        chk("gen_resume", 32'(gens > 0), 32'd1);

        // stray word into a full idle pool, then reset during WAIT
        auto_done = 1; rs_delay = 2; ready_mode = 0; lat = 2;
        do_reset();
        for (int i = 0; i < 500 && q.size() < DEPTH; i++) cyc();
        repeat (20) cyc();
        stray_req = 1'b1;
        repeat (5) cyc();
        chk("stray_fill", 32'(fill), 32'd8);
        lat = 50; ready_mode = 1;
        for (int i = 0; i < 500 && !(pend && age >= 10); i++) cyc();
        chk("mid_wait", 32'(pend), 32'd1);
        do_reset();

        // DRBG never answers
        resp_left = 0; ready_mode = 0; lat = 3;
        do_reset();
        cyc();
        chk("to_first_gen", 32'(drbg_gen), 32'd1);
        to_n = 0;
        while (!timeout_err && to_n < 400) begin
            cyc();
            to_n++;
        end
        chk("timeout_cycles", 32'(to_n), 32'd255);
        gens = 0;
        repeat (3) cyc();
        chk("timeout_regen", 32'(gens), 32'd1);
        resp_left = -1;
        repeat (80) cyc();
        chk("timeout_sticky", 32'(timeout_err), 32'd1);

        // repeated word
        resp_left = 2; ready_mode = 0; lat = 3;
        do_reset();
        src.push_back(32'hA5A5A5A5);
        src.push_back(32'hA5A5A5A5);
        repeat (40) cyc();
        chk("health_fill", 32'(fill), HEALTH ? 32'd1 : 32'd2);
        chk("health_flag", 32'(health_fail), 32'(HEALTH));
        gens = 0;
        repeat (30) cyc();
        chk("health_nogen", 32'(gens), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
